// File: rtl/frame_pixel_streamer_if.sv
// Bus bundle for frame_pixel_streamer: host load port, start control, pixel stream and status.
// Optional feature macro: STREAM_TEST_PATTERN_EN adds the pattern_sel control signal.
interface frame_pixel_streamer_if #(
    parameter int ADDR_W = 16
) ();
    logic              load_we;
    logic [ADDR_W-1:0] load_addr;
    logic [7:0]        load_data;
    logic              start;
`ifdef STREAM_TEST_PATTERN_EN
    logic              pattern_sel;
`endif
    logic [7:0]        pixel_data;
    logic              pixel_valid;
    logic [8:0]        pix_col;
    logic [8:0]        pix_row;
    logic              busy;
    logic              frame_done;
    logic [15:0]       frame_cnt;

    // Host / consumer side: drives loads and start, observes the stream.
    modport master (
`ifdef STREAM_TEST_PATTERN_EN
        output pattern_sel,
`endif
        output load_we, load_addr, load_data, start,
        input  pixel_data, pixel_valid, pix_col, pix_row, busy, frame_done, frame_cnt
    );

    // Streamer side: receives loads and start, produces the stream.
    modport slave (
`ifdef STREAM_TEST_PATTERN_EN
        input  pattern_sel,
`endif
        input  load_we, load_addr, load_data, start,
        output pixel_data, pixel_valid, pix_col, pix_row, busy, frame_done, frame_cnt
    );
endinterface

// File: rtl/frame_pixel_streamer.sv
// frame_pixel_streamer: holds one IMG_W x IMG_H greyscale frame in RAM and streams it
// row-major, one pixel per cycle, with HBLANK idle cycles between rows.
// Optional feature macro: STREAM_TEST_PATTERN_EN (pattern_sel selects a (col+row) ramp
// instead of RAM data, with identical timing).
module frame_pixel_streamer #(
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 256,
    parameter int HBLANK = 4,
    parameter int ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    frame_pixel_streamer_if.slave bus
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_HBLANK = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int unsigned      NPIX     = IMG_W * IMG_H;
    localparam logic [8:0]       COL_LAST = 9'(IMG_W - 1);
    localparam logic [8:0]       ROW_LAST = 9'(IMG_H - 1);
    localparam int               HB_W     = (HBLANK > 2) ? $clog2(HBLANK) : 1;
    localparam logic [HB_W-1:0]  HB_LAST  = HB_W'((HBLANK > 0) ? HBLANK - 1 : 0);

    logic [1:0]        state;
    logic [8:0]        col;
    logic [8:0]        row;
    logic [ADDR_W-1:0] rd_addr;
    logic [HB_W-1:0]   hb_cnt;

    logic [7:0]        mem [0:(2**ADDR_W)-1];
    logic [7:0]        rd_data;
    logic              load_ok;
    logic              rd_en;

    logic              valid_q;
    logic [8:0]        col_q;
    logic [8:0]        row_q;
    logic              done_q;
    logic [15:0]       cnt_q;

    // Host writes land only while idle and only inside the frame.
    assign load_ok = bus.load_we && (state == S_IDLE) && (32'(bus.load_addr) < NPIX);

`ifdef STREAM_TEST_PATTERN_EN
    logic       pat_sel_q;
    logic [7:0] pat_q;

    assign rd_en = (state == S_ACTIVE) && !pat_sel_q;

    // Latch the pattern selection together with an accepted start; held for the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_sel_q <= 1'b0;
        end else if (state == S_IDLE && bus.start) begin
            pat_sel_q <= bus.pattern_sel;
        end
    end

    // Ramp value for the pixel issued this cycle, aligned with the RAM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= 8'd0;
        end else if (state == S_ACTIVE) begin
            pat_q <= col[7:0] + row[7:0];
        end
    end

    assign bus.pixel_data = valid_q ? (pat_sel_q ? pat_q : rd_data) : 8'd0;
`else
    assign rd_en = (state == S_ACTIVE);

    assign bus.pixel_data = valid_q ? rd_data : 8'd0;
`endif

    // Frame RAM: host write port plus one synchronous read port for the stream.
    // NOTE: the array and its read register carry no reset so they map onto block RAM;
    // contents survive rst, and pixel_data is masked by pixel_valid instead.
    always_ff @(posedge clk) begin
        if (load_ok) begin
            mem[bus.load_addr] <= bus.load_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

    // Raster sequencer: walks col/row/rd_addr and inserts the blanking gap between rows.
    // NOTE: all state here uses non-blocking assignments so every branch sees the
    // pre-edge values of col/row/state, exactly as the flops do.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            col     <= 9'd0;
            row     <= 9'd0;
            rd_addr <= '0;
            hb_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        state   <= S_ACTIVE;
                        col     <= 9'd0;
                        row     <= 9'd0;
                        rd_addr <= '0;
                        hb_cnt  <= '0;
                    end
                end
                S_ACTIVE: begin
                    rd_addr <= rd_addr + ADDR_W'(1);
                    if (col == COL_LAST) begin
                        col <= 9'd0;
                        if (row == ROW_LAST) begin
                            state <= S_DONE;
                        end else begin
                            row <= row + 9'd1;
                            if (HBLANK > 0) begin
                                state  <= S_HBLANK;
                                hb_cnt <= '0;
                            end
                        end
                    end else begin
                        col <= col + 9'd1;
                    end
                end
                S_HBLANK: begin
                    if (hb_cnt == HB_LAST) begin
                        state <= S_ACTIVE;
                    end else begin
                        hb_cnt <= hb_cnt + HB_W'(1);
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output registers: valid and coordinates track the RAM read by one cycle;
    // frame_done and frame_cnt are updated on the drain cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            col_q   <= 9'd0;
            row_q   <= 9'd0;
            done_q  <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            valid_q <= (state == S_ACTIVE);
            done_q  <= (state == S_DONE);
            if (state == S_DONE) begin
                cnt_q <= cnt_q + 16'd1;
            end
            if (state == S_ACTIVE) begin
                col_q <= col;
                row_q <= row;
            end
        end
    end

    assign bus.pixel_valid = valid_q;
    assign bus.pix_col     = col_q;
    assign bus.pix_row     = row_q;
    assign bus.busy        = (state != S_IDLE);
    assign bus.frame_done  = done_q;
    assign bus.frame_cnt   = cnt_q;

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Self-checking bench for frame_pixel_streamer (4x3 frame; HBLANK=2 and HBLANK=0 instances).
// Expected pixels are queued when a frame is started and compared as the DUT emits them.
// Optional feature macro: STREAM_TEST_PATTERN_EN enables the test-pattern sequence.
module tb_frame_pixel_streamer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int HB = 2;
    localparam int AW = 4;
    localparam int NP = W * H;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    frame_pixel_streamer_if #(.ADDR_W(AW)) bus_a ();
    frame_pixel_streamer_if #(.ADDR_W(AW)) bus_b ();

    frame_pixel_streamer #(.IMG_W(W), .IMG_H(H), .HBLANK(HB), .ADDR_W(AW)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    frame_pixel_streamer #(.IMG_W(W), .IMG_H(H), .HBLANK(0), .ADDR_W(AW)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    typedef struct {
        logic [7:0] d;
        logic [8:0] c;
        logic [8:0] r;
        int         cyc;
    } pix_t;

    typedef struct {
        int id;
        int mult;
        int offs;
        int hb;
        int exp_cnt;
    } vec_t;

    pix_t       sbq[$];
    vec_t       vecs[3];
    logic [7:0] ram_a[NP];
    logic [7:0] ram_b[NP];
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_seen = 0;
    int last_valid_cyc = 0;
    int target = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare each emitted pixel against the head of the scoreboard; check frame_done timing.
    task automatic mon(input logic v, input logic [7:0] d, input logic [8:0] c, input logic [8:0] r,
                       input logic fd, input logic bsy);
        pix_t e;
        if (v === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pixel: got data 0x%0h col %0d row %0d, expected none (cycle %0d)",
                         d, c, r, cyc);
            end else begin
                e = sbq.pop_front();
                check("pix_data", 32'(d), 32'(e.d));
                check("pix_pos", 32'({r, c}), 32'({e.r, e.c}));
                check("pix_cycle", cyc, e.cyc);
            end
            last_valid_cyc = cyc;
        end
        if (fd === 1'b1) begin
            done_seen++;
            check("frame_done_cycle", cyc, last_valid_cyc + 1);
            check("busy_at_done", 32'(bsy), 32'd0);
        end
    endtask

    always @(negedge clk) mon(bus_a.pixel_valid, bus_a.pixel_data, bus_a.pix_col, bus_a.pix_row,
                              bus_a.frame_done, bus_a.busy);
    always @(negedge clk) mon(bus_b.pixel_valid, bus_b.pixel_data, bus_b.pix_col, bus_b.pix_row,
                              bus_b.frame_done, bus_b.busy);

    task automatic load_px(input int id, input int addr, input logic [7:0] d);
        @(negedge clk);
        if (id == 0) begin
            bus_a.load_we = 1'b1; bus_a.load_addr = AW'(addr); bus_a.load_data = d;
            if (addr < NP) ram_a[addr] = d;
        end else begin
            bus_b.load_we = 1'b1; bus_b.load_addr = AW'(addr); bus_b.load_data = d;
            if (addr < NP) ram_b[addr] = d;
        end
    endtask

    // Pulse start for one cycle; t0 is the cycle in which start is sampled.
    task automatic start_frame(input int id, output int t0);
        @(negedge clk);
        bus_a.load_we = 1'b0;
        bus_b.load_we = 1'b0;
        check("busy_before_start", 32'(id == 0 ? bus_a.busy : bus_b.busy), 32'd0);
        if (id == 0) bus_a.start = 1'b1; else bus_b.start = 1'b1;
        t0 = cyc;
        @(negedge clk);
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        check("busy_after_start", 32'(id == 0 ? bus_a.busy : bus_b.busy), 32'd1);
    endtask

    task automatic push_frame(input int id, input int t0, input int hb, input bit pat);
        pix_t e;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (pat) e.d = 8'(c + r);
                else     e.d = (id == 0) ? ram_a[r * W + c] : ram_b[r * W + c];
                e.c   = 9'(c);
                e.r   = 9'(r);
                e.cyc = t0 + 2 + r * (W + hb) + c;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic wait_frames(input int tgt);
        int n = 0;
        while (done_seen < tgt && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("frames_done", done_seen, tgt);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        int period;
        vecs[0] = '{0, 3, 0,   HB, 1};
        vecs[1] = '{0, 1, 250, HB, 2};
        vecs[2] = '{1, 3, 0,   0,  1};

        bus_a.load_we = 1'b0; bus_a.load_addr = '0; bus_a.load_data = '0; bus_a.start = 1'b0;
        bus_b.load_we = 1'b0; bus_b.load_addr = '0; bus_b.load_data = '0; bus_b.start = 1'b0;
`ifdef STREAM_TEST_PATTERN_EN
        bus_a.pattern_sel = 1'b0;
        bus_b.pattern_sel = 1'b0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_pixel_valid", 32'(bus_a.pixel_valid), 32'd0);
        check("rst_pixel_data", 32'(bus_a.pixel_data), 32'd0);
        check("rst_pix_pos", 32'({bus_a.pix_row, bus_a.pix_col}), 32'd0);
        check("rst_busy", 32'(bus_a.busy), 32'd0);
        check("rst_frame_done", 32'(bus_a.frame_done), 32'd0);
        check("rst_frame_cnt", 32'(bus_a.frame_cnt), 32'd0);
        rst = 1'b0;

        // Table-driven frames: RAM image mult*i+offs, stream it, expect the frame count.
        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < NP; i++) load_px(vecs[v].id, i, 8'(vecs[v].mult * i + vecs[v].offs));
            start_frame(vecs[v].id, t0);
            push_frame(vecs[v].id, t0, vecs[v].hb, 1'b0);
            target++;
            wait_frames(target);
            @(negedge clk);
            check("sb_empty_vec", sbq.size(), 0);
            check("frame_cnt_vec", 32'(vecs[v].id == 0 ? bus_a.frame_cnt : bus_b.frame_cnt),
                  vecs[v].exp_cnt);
        end

        // start and load pulsed mid-frame are ignored.
        for (int i = 0; i < NP; i++) load_px(0, i, 8'(3 * i));
        start_frame(0, t0);
        push_frame(0, t0, HB, 1'b0);
        repeat (5) @(negedge clk);
        bus_a.start = 1'b1; bus_a.load_we = 1'b1; bus_a.load_addr = '0; bus_a.load_data = 8'hFF;
        @(negedge clk);
        bus_a.start = 1'b0; bus_a.load_we = 1'b0;
        target++;
        wait_frames(target);
        repeat (25) @(negedge clk);
        check("no_second_frame", done_seen, target);
        check("idle_after_frame", 32'(bus_a.busy), 32'd0);
        check("frame_cnt_mid_ignore", 32'(bus_a.frame_cnt), 32'd3);
        start_frame(0, t0);
        push_frame(0, t0, HB, 1'b0);
        target++;
        wait_frames(target);
        @(negedge clk);
        check("sb_empty_rerun", sbq.size(), 0);
        check("frame_cnt_rerun", 32'(bus_a.frame_cnt), 32'd4);

        // rst during row 1 aborts the stream.
        start_frame(0, t0);
        push_frame(0, t0, HB, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 sbq.delete();
        @(negedge clk);
        check("abort_pixel_valid", 32'(bus_a.pixel_valid), 32'd0);
        check("abort_busy", 32'(bus_a.busy), 32'd0);
        check("abort_frame_cnt", 32'(bus_a.frame_cnt), 32'd0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_seen, target);

        // start held high: three back-to-back frames from address 0.
        period = (H - 1) * (W + HB) + W + 2;
        @(negedge clk);
        bus_a.start = 1'b1;
        t0 = cyc;
        for (int f = 0; f < 3; f++) push_frame(0, t0 + f * period, HB, 1'b0);
        wait_frames(target + 2);
        @(negedge clk);
        bus_a.start = 1'b0;
        target += 3;
        wait_frames(target);
        repeat (25) @(negedge clk);
        check("held_three_frames", done_seen, target);
        check("sb_empty_held", sbq.size(), 0);
        check("frame_cnt_held", 32'(bus_a.frame_cnt), 32'd3);

`ifdef STREAM_TEST_PATTERN_EN
        // Test pattern: pixel = col + row, same timing as RAM mode.
        bus_a.pattern_sel = 1'b1;
        start_frame(0, t0);
        bus_a.pattern_sel = 1'b0;
        push_frame(0, t0, HB, 1'b1);
        target++;
        wait_frames(target);
        @(negedge clk);
        check("sb_empty_pattern", sbq.size(), 0);
        check("frame_cnt_pattern", 32'(bus_a.frame_cnt), 32'd4);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
